instruction_fetch_stage: RTL and testbench

//  Fetch stage plus IF/ID pipeline register directly upstream of InstructionDecode.

---
 rtl/instruction_fetch_stage.sv | 157 +++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC, keeps at most one instruction-memory request in flight, holds a
// single-entry skid buffer for responses that arrive while decode is stalled,
// and squashes wrong-path responses after a branch/jump redirect.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PCAdder_out,
    output logic        IF_Valid,
    output logic [31:0] PC_out
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;

    logic [31:0] req_pc_next;
    logic [31:0] deliver_data;
    logic        deliver;
    logic        granted;

    // The two target LSBs are forced to zero, so they are deliberately not used.
    logic        unused_target_lsbs;
    assign unused_target_lsbs = ^RedirectTarget[1:0];

    assign req_pc_next = req_pc_q + 32'd4;
    assign granted     = req_q & imem_gnt;

    // Next-state logic for the fetch FSM, PC, skid buffer and IF/ID register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_d       = skid_q;
        instr_d      = instr_q;
        pc_plus4_d   = pc_plus4_q;
        valid_d      = valid_q;
        deliver      = 1'b0;
        deliver_data = 32'd0;

        if (Redirect) begin
            pc_d    = {RedirectTarget[31:2], 2'b00};
            instr_d = 32'd0;
            valid_d = 1'b0;
            skid_d  = 32'd0;
            case (state_q)
                FETCH:   state_d = granted ? DROP : FETCH;
                WAIT:    state_d = imem_rvalid ? FETCH : DROP;
                DROP:    state_d = imem_rvalid ? FETCH : DROP;
                HOLD:    state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (granted) begin
                        req_pc_d = pc_q;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (!Stall) begin
                            deliver      = 1'b1;
                            deliver_data = imem_rdata;
                            pc_d         = req_pc_next;
                            state_d      = FETCH;
                        end else begin
                            skid_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        deliver      = 1'b1;
                        deliver_data = skid_q;
                        skid_d       = 32'd0;
                        pc_d         = req_pc_next;
                        state_d      = FETCH;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase

            if (deliver) begin
                instr_d    = deliver_data;
                pc_plus4_d = req_pc_next;
                valid_d    = 1'b1;
            end else if (!Stall) begin
                instr_d = 32'd0;
                valid_d = 1'b0;
            end
        end

        req_d = (state_d == FETCH);
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            skid_q     <= 32'd0;
            instr_q    <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            skid_q     <= skid_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign PCAdder_out = pc_plus4_q;
    assign IF_Valid    = valid_q;
    assign PC_out      = pc_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage: a small instruction-memory model grants
// planned fetches, checks their addresses and queues the expected IF/ID contents;
// every new IF/ID instruction is popped from that queue and compared.
module tb_instruction_fetch_stage;

    typedef struct {
        logic [31:0] addr;
        logic        drop;
        logic [31:0] exp_instr;
        logic [31:0] exp_pcadd;
    } fetch_vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcadd;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PCAdder_out;
    logic        IF_Valid;
    logic [31:0] PC_out;

    fetch_vec_t  vecs [11];
    fetch_vec_t  plan_q [$];
    exp_t        exp_q [$];

    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    logic        saw_gnt;
    logic        saw_rvalid;

    logic        pend;
    int          cnt;
    logic [31:0] pend_addr;
    fetch_vec_t  gv;

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .Instruction    (Instruction),
        .PCAdder_out    (PCAdder_out),
        .IF_Valid       (IF_Valid),
        .PC_out         (PC_out)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Instruction memory: grants only planned fetches, answers after 'lat' cycles.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        pend        = 1'b0;
        cnt         = 0;
        pend_addr   = 32'd0;
        forever begin
            @(negedge Clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (!Reset) begin
                pend = 1'b0;
                cnt  = 0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(pend_addr);
                        pend        = 1'b0;
                    end
                end
                if (!pend && !imem_rvalid && imem_req && plan_q.size() > 0) begin
                    gv        = plan_q.pop_front();
                    imem_gnt  = 1'b1;
                    pend      = 1'b1;
                    cnt       = lat;
                    pend_addr = imem_addr;
                    check_output("fetch_addr", imem_addr, gv.addr);
                    if (!gv.drop) exp_q.push_back('{instr: gv.exp_instr, pcadd: gv.exp_pcadd});
                end
            end
        end
    end

    // One clock cycle of stimulus; a new IF/ID instruction is checked against the scoreboard.
    task automatic apply_stimulus(input logic st, input logic rd, input logic [31:0] tgt);
        exp_t e;
        @(negedge Clk);
        #1;
        Stall          = st;
        Redirect       = rd;
        RedirectTarget = tgt;
        saw_gnt        = imem_gnt;
        saw_rvalid     = imem_rvalid;
        @(posedge Clk);
        #1;
        if (!st && !rd && IF_Valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_instr", Instruction, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check_output("sb_instruction", Instruction, e.instr);
                check_output("sb_pcadder", PCAdder_out, e.pcadd);
            end
        end
    endtask

    task automatic plan(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) plan_q.push_back(vecs[i]);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((plan_q.size() > 0 || exp_q.size() > 0) && n < 60) begin
            apply_stimulus(1'b0, 1'b0, 32'd0);
            n++;
        end
        check_output({name, "_drained"}, 32'(plan_q.size() + exp_q.size()), 32'd0);
        plan_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        Stall = 1'b0;
        Redirect = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
    endtask

    // Main test sequence.
    initial begin
        Reset          = 1'b0;
        Stall          = 1'b0;
        Redirect       = 1'b0;
        RedirectTarget = 32'd0;
        saw_gnt        = 1'b0;
        saw_rvalid     = 1'b0;

        vecs[0]  = '{32'h0000_0000, 1'b0, 32'hA000_0000, 32'h0000_0004};
        vecs[1]  = '{32'h0000_0004, 1'b0, 32'hA000_0004, 32'h0000_0008};
        vecs[2]  = '{32'h0000_0008, 1'b0, 32'hA000_0008, 32'h0000_000C};
        vecs[3]  = '{32'h0000_0000, 1'b0, 32'hA000_0000, 32'h0000_0004};
        vecs[4]  = '{32'h0000_0004, 1'b0, 32'hA000_0004, 32'h0000_0008};
        vecs[5]  = '{32'h0000_0008, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[6]  = '{32'h0000_0040, 1'b0, 32'hA000_0040, 32'h0000_0044};
        vecs[7]  = '{32'hFFFF_FFFC, 1'b0, 32'h5FFF_FFFC, 32'h0000_0000};
        vecs[8]  = '{32'h0000_0000, 1'b0, 32'hA000_0000, 32'h0000_0004};
        vecs[9]  = '{32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{32'h0000_0000, 1'b0, 32'hA000_0000, 32'h0000_0004};

        // Reset values
        repeat (2) @(posedge Clk);
        #1;
        check_output("rst_instr", Instruction, 32'd0);
        check_output("rst_pcadder", PCAdder_out, 32'd0);
        check_output("rst_valid", {31'd0, IF_Valid}, 32'd0);
        check_output("rst_req", {31'd0, imem_req}, 32'd0);
        check_output("rst_pc", PC_out, 32'd0);
        check_output("rst_addr", imem_addr, 32'd0);
        #2;
        Reset = 1'b1;

        // Streaming fetch of 0,4,8 with a one-cycle memory
        lat = 1;
        plan(0, 2);
        drain("t1");

        // Stall while the response for address 4 returns
        do_reset();
        plan(3, 3);
        drain("t2a");
        plan(4, 4);
        apply_stimulus(1'b1, 1'b0, 32'd0);
        check_output("t2_gnt", {31'd0, saw_gnt}, 32'd1);
        check_output("t2_keep_instr0", Instruction, 32'hA000_0000);
        apply_stimulus(1'b1, 1'b0, 32'd0);
        check_output("t2_rvalid", {31'd0, saw_rvalid}, 32'd1);
        check_output("t2_hold_instr", Instruction, 32'hA000_0000);
        check_output("t2_hold_valid", {31'd0, IF_Valid}, 32'd1);
        check_output("t2_hold_req", {31'd0, imem_req}, 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'd0);
        check_output("t2_hold_pcadder", PCAdder_out, 32'h4);
        check_output("t2_hold_req2", {31'd0, imem_req}, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        check_output("t2_released", 32'(exp_q.size()), 32'd0);
        check_output("t2_valid", {31'd0, IF_Valid}, 32'd1);
        check_output("t2_next_req", {31'd0, imem_req}, 32'd1);
        check_output("t2_next_addr", imem_addr, 32'h8);

        // Redirect while waiting on address 8
        lat = 3;
        plan(5, 6);
        apply_stimulus(1'b1, 1'b0, 32'd0);
        check_output("t3_gnt", {31'd0, saw_gnt}, 32'd1);
        apply_stimulus(1'b0, 1'b1, 32'h0000_0040);
        check_output("t3_flush_valid", {31'd0, IF_Valid}, 32'd0);
        check_output("t3_flush_instr", Instruction, 32'd0);
        check_output("t3_pc", PC_out, 32'h40);
        check_output("t3_drop_req", {31'd0, imem_req}, 32'd0);
        drain("t3");

        // Redirect together with Stall flushes a valid IF/ID
        lat = 1;
        check_output("t4_pre_valid", {31'd0, IF_Valid}, 32'd1);
        apply_stimulus(1'b1, 1'b1, 32'h0000_0043);
        check_output("t4_valid", {31'd0, IF_Valid}, 32'd0);
        check_output("t4_instr", Instruction, 32'd0);
        check_output("t4_pc", PC_out, 32'h40);
        check_output("t4_addr", imem_addr, 32'h40);
        check_output("t4_req", {31'd0, imem_req}, 32'd1);

        // PC wrap-around at the top of the address space
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        check_output("t6_pc", PC_out, 32'hFFFF_FFFC);
        plan(7, 8);
        drain("t6");
        check_output("t6_pc_after", PC_out, 32'h4);

        // Asynchronous reset while a request is in flight
        lat = 3;
        plan(9, 9);
        apply_stimulus(1'b1, 1'b0, 32'd0);
        check_output("t5_gnt", {31'd0, saw_gnt}, 32'd1);
        apply_stimulus(1'b1, 1'b0, 32'd0);
        #2;
        Reset = 1'b0;
        #1;
        check_output("t5_instr", Instruction, 32'd0);
        check_output("t5_pcadder", PCAdder_out, 32'd0);
        check_output("t5_valid", {31'd0, IF_Valid}, 32'd0);
        check_output("t5_req", {31'd0, imem_req}, 32'd0);
        check_output("t5_pc", PC_out, 32'd0);
        Stall = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        lat = 1;
        plan(10, 10);
        drain("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
